inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 18 +
 rtl/inst_fetch_fifo.sv | 48 ++++
 rtl/inst_fetch.sv | 92 +++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, stall/reset/enable levels and
// the {pc,inst} entry carried through the fetch buffer.
package inst_fetch_pkg;
  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [INST_ADDR_BUS-1:0] pc;
    logic [INST_BUS-1:0]      inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry fetch buffer; entry 0 is always the head. flush_tail drops every
// entry behind the head (including the head's successor when the head pops).
module fetch_fifo
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush_tail,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t [1:0] ent_q, ent_d;
  logic [1:0]         cnt_q, cnt_d, keep;
  logic               do_pop;

  always_comb begin
    ent_d  = ent_q;
    do_pop = pop && (cnt_q != 2'd0);
    keep   = cnt_q;
    if (do_pop) begin
      ent_d[0] = ent_q[1];
      keep     = cnt_q - 2'd1;
    end
    if (flush_tail)
      keep = (do_pop || cnt_q == 2'd0) ? 2'd0 : 2'd1;
    cnt_d = keep;
    if (push && keep != 2'd2) begin
      ent_d[keep[0]] = push_entry;
      cnt_d          = keep + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      ent_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = ent_q[0];
  assign count = cnt_q;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding ROM request, 2-entry {pc,inst} buffer
// feeding IF/ID, branch redirect with delay-slot delivery.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               stall,
  input  logic                     branch_flag_i,
  input  logic [INST_ADDR_BUS-1:0] branch_target_address_i,
  output logic                     rom_ce_o,
  output logic [INST_ADDR_BUS-1:0] rom_addr_o,
  input  logic                     rom_ready_i,
  input  logic [INST_BUS-1:0]      rom_data_i,
  output logic [INST_ADDR_BUS-1:0] if_pc,
  output logic [INST_BUS-1:0]      if_inst,
  output logic                     stallreq_if
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t                   state_q, state_d;
  logic [INST_ADDR_BUS-1:0] fetch_pc_q, fetch_pc_d;
  logic [INST_ADDR_BUS-1:0] req_pc_q, req_pc_d;
  logic                     pop, br, issue, push;
  logic [1:0]               count;
  fetch_entry_t             head, push_entry;
  logic                     unused_bits;

  assign unused_bits = ^{stall[5:2], branch_target_address_i[1:0]};

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush_tail (br),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

  assign push_entry = '{pc: req_pc_q, inst: rom_data_i};

  always_comb begin
    pop        = (stall[1] == NO_STOP) && (count != 2'd0);
    br         = branch_flag_i && pop;
    // rst gate keeps the combinational request quiet while reset is held
    issue      = (rst != RST_ENABLE) && (state_q == S_IDLE) &&
                 (stall[0] == NO_STOP) && (count != 2'd2) && !br;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (rom_ready_i) begin
          push    = !br;
          state_d = S_IDLE;
        end else if (br) begin
          state_d = S_DROP;
        end
      end
      S_DROP: if (rom_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (br) fetch_pc_d = {branch_target_address_i[31:2], 2'b00};

    rom_ce_o   = (state_q != S_IDLE || issue) ? CHIP_ENABLE : CHIP_DISABLE;
    rom_addr_o = (state_q != S_IDLE) ? req_pc_q :
                 (issue ? fetch_pc_q : ZERO_WORD);
    if_pc       = (count != 2'd0) ? head.pc   : ZERO_WORD;
    if_inst     = (count != 2'd0) ? head.inst : ZERO_WORD;
    stallreq_if = (count == 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end
endmodule
